seq_mult_acc: RTL and testbench

//  Parametrised sequential shift-add multiplier with its own control FSM and

---
 rtl/seq_mult_acc_if.sv | 30 +++
 rtl/seq_mult_acc.sv | 107 ++++++++++
 tb/tb_seq_mult_acc.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_acc_if.sv
// Bus between a requester and the sequential multiplier: start/done handshake,
// operands and product, plus the FSM state for observation.
//
// Handshake: the requester raises Start with valid Signed/operands; the request
// is taken on the first rising edge where the multiplier can accept it. Busy is
// high from that edge until the result edge. Done is a one-cycle pulse that
// marks Produto valid. Start while Busy is low or in the result cycle is taken.
// A Start at any other time is dropped, not queued.
interface seq_mult_acc_if #(
   parameter int WIDTH = 16
);
   logic                 Start;
   logic                 Signed;
   logic [WIDTH-1:0]     Multiplicando;
   logic [WIDTH-1:0]     Multiplicador;
   logic                 Busy;
   logic                 Done;
   logic [2*WIDTH-1:0]   Produto;
   logic [1:0]           dbg_state;

   modport master (
      output Start, Signed, Multiplicando, Multiplicador,
      input  Busy, Done, Produto, dbg_state
   );

   modport slave (
      input  Start, Signed, Multiplicando, Multiplicador,
      output Busy, Done, Produto, dbg_state
   );
endinterface

// File: rtl/seq_mult_acc.sv
// Sequential shift-add multiplier, one bit of the multiplier per cycle.
// Signed operands are converted to magnitudes on accept, and the sign is
// applied to the final product. The result edge may also take the next
// request, so the operation rate is one per WIDTH+1 cycles.
module seq_mult_acc #(
   parameter int WIDTH = 16
) (
   input logic           Clk,
   input logic           Reset,
   seq_mult_acc_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH:0]     acc_q;
   logic [WIDTH-1:0]     mcand_q;
   logic                 neg_q;
   logic [CW-1:0]        count_q;
   logic [2*WIDTH-1:0]   prod_q;
   logic                 done_q;

   logic                 accept;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic                 neg_d;
   logic [WIDTH:0]       upper;

   // A request is taken in IDLE and also on the result edge (no bubble).
   assign accept = bus.Start && ((state_q == S_IDLE) || (state_q == S_FINISH));

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which
   // still fits as an unsigned WIDTH-bit number.
   always_comb begin
      mag_a = bus.Multiplicando;
      mag_b = bus.Multiplicador;
      neg_d = 1'b0;
      if (bus.Signed) begin
         if (bus.Multiplicando[WIDTH-1]) mag_a = -bus.Multiplicando;
         if (bus.Multiplicador[WIDTH-1]) mag_b = -bus.Multiplicador;
         neg_d = bus.Multiplicando[WIDTH-1] ^ bus.Multiplicador[WIDTH-1];
      end
   end

   // Conditional add of the multiplicand into the upper half; WIDTH+1 bits
   // hold the sum of two WIDTH-bit values, so it cannot overflow.
   always_comb begin
      upper = acc_q[2*WIDTH:WIDTH];
      if (acc_q[0]) upper = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_RUN;
         S_RUN:    if (count_q == CW'(1)) state_d = S_FINISH;
         S_FINISH: state_d = accept ? S_RUN : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      bus.Busy      = (state_q != S_IDLE);
      bus.Done      = done_q;
      bus.Produto   = prod_q;
      bus.dbg_state = state_q;
   end

   // Datapath: load on accept, iterate in RUN, publish the signed result in FINISH.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         acc_q   <= '0;
         mcand_q <= '0;
         neg_q   <= 1'b0;
         count_q <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == S_FINISH) begin
            prod_q <= neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
            done_q <= 1'b1;
         end
         if (accept) begin
            acc_q   <= {{(WIDTH+1){1'b0}}, mag_b};
            mcand_q <= mag_a;
            neg_q   <= neg_d;
            count_q <= CW'(WIDTH);
         end else if (state_q == S_RUN) begin
            acc_q   <= {1'b0, upper, acc_q[WIDTH-1:1]};
            count_q <= count_q - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_seq_mult_acc.sv
// Directed bench for seq_mult_acc: a WIDTH=16 instance driven from a vector
// table and hand-written sequences, plus a WIDTH=4 instance swept over every
// operand pair in both modes.
module tb_seq_mult_acc;
   logic Clk;
   logic Reset;
   int   total;
   int   bad;

   seq_mult_acc_if #(.WIDTH(16)) m16 ();
   seq_mult_acc_if #(.WIDTH(4))  m4 ();

   seq_mult_acc #(.WIDTH(16)) u16 (.Clk(Clk), .Reset(Reset), .bus(m16.slave));
   seq_mult_acc #(.WIDTH(4))  u4  (.Clk(Clk), .Reset(Reset), .bus(m4.slave));

   // Clock and reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sgn;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // One WIDTH=16 operation: accept at E0, wait for Done, check latency,
   // Busy through the run, product, one-cycle Done and held product.
   // With do_chg set, operands and mode are altered before E5.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                         input logic [31:0] exp, input string name, input bit do_chg);
      int   lat;
      logic busy_ok;
      m16.Multiplicando = a;
      m16.Multiplicador = b;
      m16.Signed        = sgn;
      m16.Start         = 1'b1;
      tick();
      m16.Start = 1'b0;
      lat     = 0;
      busy_ok = 1'b1;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         if (!m16.Busy) busy_ok = 1'b0;
         if (do_chg && i == 5) begin
            m16.Multiplicando = ~a;
            m16.Multiplicador = b + 16'd7;
            m16.Signed        = ~sgn;
         end
         tick();
         if (m16.Done) lat = i;
      end
      chk({name, "_latency"}, 64'(lat), 64'd17);
      chk({name, "_busy_run"}, 64'(busy_ok), 64'd1);
      chk({name, "_prod"}, 64'(m16.Produto), 64'(exp));
      tick();
      chk({name, "_done_pulse"}, 64'(m16.Done), 64'd0);
      chk({name, "_busy_after"}, 64'(m16.Busy), 64'd0);
      chk({name, "_prod_held"}, 64'(m16.Produto), 64'(exp));
   endtask

   // One WIDTH=4 operation checked against an integer product.
   task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sgn);
      int         ia, ib, lat;
      logic [7:0] exp;
      ia  = (sgn && a[3]) ? int'(a) - 16 : int'(a);
      ib  = (sgn && b[3]) ? int'(b) - 16 : int'(b);
      exp = 8'(ia * ib);
      m4.Multiplicando = a;
      m4.Multiplicador = b;
      m4.Signed        = sgn;
      m4.Start         = 1'b1;
      tick();
      m4.Start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 12 && lat == 0; i++) begin
         tick();
         if (m4.Done) lat = i;
      end
      chk("w4_latency", 64'(lat), 64'd5);
      chk("w4_prod", 64'(m4.Produto), 64'(exp));
   endtask

   initial begin
      int   n_done;
      logic seen;
      total = 0;
      bad   = 0;

      vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_max_max"};
      vecs[1]  = '{16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_min_min"};
      vecs[2]  = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, "s_min_one"};
      vecs[3]  = '{16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, "s_m3_7"};
      vecs[4]  = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F, "u_3_5"};
      vecs[5]  = '{16'h0000, 16'hFFFF, 1'b1, 32'h00000000, "s_zero_neg"};
      vecs[6]  = '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF, "s_m1_1"};
      vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "s_m1_m1"};
      vecs[8]  = '{16'h1234, 16'h0010, 1'b0, 32'h00012340, "u_shift"};
      vecs[9]  = '{16'h8000, 16'hFFFF, 1'b0, 32'h7FFF8000, "u_8000_ffff"};
      vecs[10] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, "s_max_max"};
      vecs[11] = '{16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, "u_ffff_2"};

      m16.Start = 1'b0; m16.Signed = 1'b0; m16.Multiplicando = '0; m16.Multiplicador = '0;
      m4.Start  = 1'b0; m4.Signed  = 1'b0; m4.Multiplicando  = '0; m4.Multiplicador  = '0;
      Reset = 1'b1;
      repeat (3) tick();
      Reset = 1'b0;
      tick();
      chk("reset_busy", 64'(m16.Busy), 64'd0);
      chk("reset_done", 64'(m16.Done), 64'd0);
      chk("reset_prod", 64'(m16.Produto), 64'd0);
      chk("reset_state", 64'(m16.dbg_state), 64'd0);

      // Vector table
      for (int i = 0; i < 12; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, vecs[i].name, 1'b0);

      // Reset mid-run: abort with no Done, outputs cleared.
      m16.Multiplicando = 16'h00FF;
      m16.Multiplicador = 16'h0101;
      m16.Signed        = 1'b0;
      m16.Start         = 1'b1;
      tick();
      m16.Start = 1'b0;
      repeat (7) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("midrst_busy", 64'(m16.Busy), 64'd0);
      chk("midrst_done", 64'(m16.Done), 64'd0);
      chk("midrst_prod", 64'(m16.Produto), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (m16.Done) seen = 1'b1;
      end
      chk("midrst_no_done", 64'(seen), 64'd0);
      run_op(16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, "after_rst", 1'b0);

      // Operand and mode changes while busy are ignored.
      run_op(16'h0100, 16'h0020, 1'b0, 32'h00002000, "opchg", 1'b1);

      // Back-to-back with Start held high for 40 cycles.
      m16.Multiplicando = 16'h0003;
      m16.Multiplicador = 16'h0005;
      m16.Signed        = 1'b1;
      m16.Start         = 1'b1;
      tick();
      m16.Multiplicando = 16'h0000;
      m16.Multiplicador = 16'hFFFF;
      n_done = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (m16.Done) begin
            n_done++;
            if (n_done == 1) begin
               chk("b2b_first_edge", 64'(i), 64'd17);
               chk("b2b_first_prod", 64'(m16.Produto), 64'd15);
            end else if (n_done == 2) begin
               chk("b2b_second_edge", 64'(i), 64'd34);
               chk("b2b_second_prod", 64'(m16.Produto), 64'd0);
            end
         end
      end
      m16.Start = 1'b0;
      chk("b2b_done_count", 64'(n_done), 64'd2);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tick();

      // WIDTH=4 exhaustive sweep, both modes.
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               run4(4'(a), 4'(b), 1'(s));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
